// File: rtl/control_unit.sv
// control_unit: sequencing FSM for the operative datapath (X/S/H registers,
// 3-level mux tree, add/subtract ULA). A start pulse latches an opcode and a
// repeat count; the FSM then walks LOADX -> STEP1 -> STEP2(xN) -> DONE and
// drives every datapath control line as a pure decode of registered state.
module control_unit #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             load_x,
  output logic             load_s,
  output logic             load_h,
  output logic             H,
  output logic [1:0]       sel_m0,
  output logic [1:0]       sel_m1,
  output logic [1:0]       sel_m2
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADX = 3'd1,
    S_STEP1 = 3'd2,
    S_STEP2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Mux select encodings, named by what they route.
  localparam logic [1:0] M0_A    = 2'b00;
  localparam logic [1:0] M0_B    = 2'b10;
  localparam logic [1:0] M0_C    = 2'b11;
  localparam logic [1:0] M1_M0   = 2'b00;
  localparam logic [1:0] M1_X    = 2'b01;
  localparam logic [1:0] M1_S    = 2'b10;
  localparam logic [1:0] M1_H    = 2'b11;
  localparam logic [1:0] M2_X    = 2'b00;
  localparam logic [1:0] M2_M0   = 2'b01;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, latched opcode and remaining STEP2 iterations; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; op/count are only looked at when a start is accepted in IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          // A zero count still performs one accumulation step.
          cnt_d   = (count == '0) ? CNT_W'(1) : count;
          state_d = S_LOADX;
        end
      end
      S_LOADX: state_d = S_STEP1;
      S_STEP1: state_d = S_STEP2;
      S_STEP2: begin
        if (op_q[1]) begin
          // ops 10/11 combine H with B/C exactly once.
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath control decode from registered state and opcode only (no live inputs).
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    load_x = 1'b0;
    load_s = 1'b0;
    load_h = 1'b0;
    H      = 1'b0;
    sel_m0 = M0_A;
    sel_m1 = M1_M0;
    sel_m2 = M2_X;
    case (state_q)
      S_IDLE: ;
      S_LOADX: begin
        busy   = 1'b1;
        load_x = 1'b1;
      end
      S_STEP1: begin
        busy = 1'b1;
        case (op_q)
          2'b00, 2'b01: begin
            // S = X +/- A
            sel_m0 = M0_A;
            sel_m1 = M1_X;
            sel_m2 = M2_M0;
            H      = op_q[0];
            load_s = 1'b1;
          end
          2'b10: begin
            // H = X + X
            sel_m1 = M1_X;
            sel_m2 = M2_X;
            load_h = 1'b1;
          end
          default: begin
            // H = A + X
            sel_m0 = M0_A;
            sel_m1 = M1_M0;
            sel_m2 = M2_X;
            load_h = 1'b1;
          end
        endcase
      end
      S_STEP2: begin
        // op[0] picks B(add)/C(subtract); op[1] picks S or H as the accumulator.
        busy   = 1'b1;
        sel_m0 = op_q[0] ? M0_C : M0_B;
        sel_m1 = op_q[1] ? M1_H : M1_S;
        sel_m2 = M2_M0;
        H      = op_q[0];
        load_s = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with directed and random operations and
// runs a behavioural datapath (X/S/H, mux tree, ULA) from its control outputs.
// Results, latency and load counts are compared against arithmetic expectations.
module tb_control_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic             busy, done, load_x, load_s, load_h, H;
  logic [1:0]       sel_m0, sel_m1, sel_m2;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural datapath state and its data inputs.
  logic [15:0] x_m, s_m, h_m, m0_m;
  logic [15:0] x_in, a_in, b_in, c_in;

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .count(count),
    .busy(busy), .done(done), .load_x(load_x), .load_s(load_s), .load_h(load_h),
    .H(H), .sel_m0(sel_m0), .sel_m1(sel_m1), .sel_m2(sel_m2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the datapath, using the control values sampled this cycle.
  task automatic dp_step();
    logic [15:0] m1, m2, u, m0n;
    case (sel_m0)
      2'b00: m0n = a_in;
      2'b01: m0n = m0_m;
      2'b10: m0n = b_in;
      default: m0n = c_in;
    endcase
    case (sel_m1)
      2'b00: m1 = m0n;
      2'b01: m1 = x_m;
      2'b10: m1 = s_m;
      default: m1 = h_m;
    endcase
    case (sel_m2)
      2'b00: m2 = x_m;
      2'b01: m2 = m0n;
      2'b10: m2 = s_m;
      default: m2 = h_m;
    endcase
    u = H ? (m1 - m2) : (m1 + m2);
    m0_m = m0n;
    if (load_x) x_m = x_in;
    if (load_s) s_m = u;
    if (load_h) h_m = u;
  endtask

  function automatic int n_steps(input logic [1:0] o, input logic [CNT_W-1:0] c);
    if (o[1]) return 1;
    return (c == 0) ? 1 : int'(c);
  endfunction

  function automatic logic [15:0] exp_res(input logic [1:0] o, input int n,
                                          input logic [15:0] x, a, b, c);
    logic [15:0] r;
    case (o)
      2'b00: begin r = x + a; for (int i = 0; i < n; i++) r = r + b; end
      2'b01: begin r = x - a; for (int i = 0; i < n; i++) r = r - c; end
      2'b10: r = x + x + b;
      default: r = a + x - c;
    endcase
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ctrl"}, {load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2}, 0);
  endtask

  // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic run_op(input logic [1:0] o, input logic [CNT_W-1:0] c,
                        input logic [15:0] x, a, b, c_val);
    int nx, ns, nh, busy_low, dcyc, done_loads, n;
    logic got_done;
    logic [15:0] res;
    x_in = x; a_in = a; b_in = b; c_in = c_val;
    n = n_steps(o, c);
    start = 1'b1; op = o; count = c;
    nx = 0; ns = 0; nh = 0; busy_low = 0; dcyc = 0; done_loads = 0;
    got_done = 1'b0; res = '0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        op    = 2'($urandom);
        count = CNT_W'($urandom);
      end
      if (!busy) busy_low++;
      nx += int'(load_x); ns += int'(load_s); nh += int'(load_h);
      if (done) begin
        got_done   = 1'b1;
        dcyc       = k;
        res        = s_m;
        done_loads = int'(load_x) + int'(load_s) + int'(load_h);
      end
      dp_step();
    end
    check("done_seen", got_done, 1);
    check("latency", dcyc, 3 + n);
    check("result", res, exp_res(o, n, x, a, b, c_val));
    check("n_load_x", nx, 1);
    check("n_load_s", ns, o[1] ? 1 : 1 + n);
    check("n_load_h", nh, o[1] ? 1 : 0);
    check("busy_gap", busy_low, 0);
    check("done_loads", done_loads, 0);
    @(negedge clk);
    check_idle("post_done");
    dp_step();
  endtask

  initial begin
    int t, acc_cyc, naccept, ndone, idle_run, nld;
    logic [1:0] acc_op;
    logic [CNT_W-1:0] acc_cnt;
    logic first_rise, prev_busy, exited, bsy;
    logic [15:0] s_hold;

    x_m = '0; s_m = '0; h_m = '0; m0_m = '0;
    x_in = '0; a_in = '0; b_in = '0; c_in = '0;
    rst = 1'b1; start = 1'b1; op = 2'b11; count = 4'd3;

    // Reset wins over start.
    repeat (3) @(negedge clk);
    check_idle("reset");
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Reset during STEP2 of op 00, count 5.
    x_in = 16'd5; a_in = 16'd3; b_in = 16'd2; c_in = 16'd1;
    start = 1'b1; op = 2'b00; count = 4'd5;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      dp_step();
    end
    rst = 1'b1;
    s_hold = s_m;
    @(negedge clk);
    check_idle("rst_abort");
    dp_step();
    rst = 1'b0;
    nld = 0;
    repeat (4) begin
      @(negedge clk);
      nld += int'(load_x) + int'(load_s) + int'(load_h);
      dp_step();
    end
    check("rst_no_loads", nld, 0);
    check("rst_s_held", s_m, s_hold);
    check_idle("rst_settled");

    // Directed operations.
    run_op(2'b00, 4'd1, 16'd5, 16'd3, 16'd2, 16'd1);   // 10
    run_op(2'b01, 4'd3, 16'd5, 16'd3, 16'd2, 16'd1);   // FFFF
    run_op(2'b10, 4'd7, 16'd5, 16'd3, 16'd2, 16'd1);   // 12
    run_op(2'b11, 4'd0, 16'd5, 16'd3, 16'd2, 16'd1);   // 7
    run_op(2'b00, 4'd0, 16'd5, 16'd3, 16'd2, 16'd1);   // 10
    run_op(2'b00, 4'd15, 16'hFFF0, 16'h0020, 16'h1000, 16'd0);
    run_op(2'b01, 4'd15, 16'd0, 16'd1, 16'd0, 16'hFFFF);

    // Random operations.
    for (int i = 0; i < 10; i++)
      run_op(2'($urandom), CNT_W'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));

    // start held high with op/count toggling every cycle.
    x_in = 16'd9; a_in = 16'd4; b_in = 16'd3; c_in = 16'd2;
    t = 0; start = 1'b1; op = 2'($urandom); count = CNT_W'($urandom);
    acc_op = op; acc_cnt = count; acc_cyc = 0; naccept = 1; ndone = 0;
    idle_run = 0; first_rise = 1'b1; prev_busy = 1'b0; exited = 1'b0;
    for (int k = 0; k < 300 && !exited; k++) begin
      @(negedge clk);
      t++;
      bsy = busy;
      if (done) begin
        ndone++;
        check("hold_latency", t - acc_cyc, 3 + n_steps(acc_op, acc_cnt));
        check("hold_result", s_m,
              exp_res(acc_op, n_steps(acc_op, acc_cnt), x_in, a_in, b_in, c_in));
      end
      if (bsy && !prev_busy) begin
        if (!first_rise) check("hold_idle_gap", idle_run, 1);
        first_rise = 1'b0;
      end
      idle_run = bsy ? 0 : idle_run + 1;
      prev_busy = bsy;
      dp_step();
      op = 2'($urandom);
      count = CNT_W'($urandom);
      if (!bsy) begin
        if (ndone >= 4) begin
          start = 1'b0;
          exited = 1'b1;
        end else begin
          acc_op = op; acc_cnt = count; acc_cyc = t; naccept++;
        end
      end
    end
    check("hold_finished", exited, 1);
    check("hold_done_count", ndone, 4);
    check("hold_accepts", naccept, ndone);
    @(negedge clk);
    check_idle("hold_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
